// File: rtl/eth_fcs_if.sv
// eth_fcs_if: nibble-stream bus between the JPEG-to-Ethernet bridge, the FCS appender and the MII
// TX pins.
//   with_usr       [3:0] frame nibble (preamble, SFD, data), low nibble of each byte first
//   with_usr_valid       high for the contiguous duration of one frame
//   eth_txd        [3:0] MII TXD
//   eth_tx_en            MII TX_EN
//   tx_busy              frame in flight or inter-frame gap still running
//   frame_err            one-cycle framing error pulse
//   drop_cnt       [7:0] saturating count of discarded input frames
// master: bridge/MII side. slave: eth_fcs_append.
interface eth_fcs_if;
  logic [3:0] with_usr;
  logic       with_usr_valid;
  logic [3:0] eth_txd;
  logic       eth_tx_en;
  logic       tx_busy;
  logic       frame_err;
  logic [7:0] drop_cnt;

  modport master (
    output with_usr, with_usr_valid,
    input  eth_txd, eth_tx_en, tx_busy, frame_err, drop_cnt
  );

  modport slave (
    input  with_usr, with_usr_valid,
    output eth_txd, eth_tx_en, tx_busy, frame_err, drop_cnt
  );
endinterface

// File: rtl/eth_fcs_append.sv
// eth_fcs_append: computes the Ethernet CRC-32 over the final post-SFD nibble stream, appends the
// 8-nibble FCS, then enforces the inter-frame gap. All logic runs on the rising edge of eth_clk.
//   eth_clk  MII TX clock
//   rst_n    synchronous active-low reset
//   bus      eth_fcs_if.slave: with_usr/with_usr_valid in; eth_txd, eth_tx_en, tx_busy,
//            frame_err, drop_cnt out (all registered)
// Parameters:
//   IFG_NIBBLES       idle nibbles forced after each FCS (or aborted frame)
//   MIN_DATA_NIBBLES  minimum post-SFD nibbles before FCS (only with ETH_FCS_PAD_EN)
// Build option: define ETH_FCS_PAD_EN to zero-pad short frames up to MIN_DATA_NIBBLES.
module eth_fcs_append #(
`ifdef ETH_FCS_PAD_EN
  parameter int unsigned MIN_DATA_NIBBLES = 120,
`endif
  parameter int unsigned IFG_NIBBLES      = 24
) (
  input logic      eth_clk,
  input logic      rst_n,
  eth_fcs_if.slave bus
);

  localparam logic [31:0] CrcPoly = 32'hEDB88320;
  localparam logic [31:0] CrcInit = 32'hFFFFFFFF;
  localparam int unsigned IfgW    = $clog2(IFG_NIBBLES + 1);
`ifdef ETH_FCS_PAD_EN
  localparam logic [10:0] MinNib  = 11'(MIN_DATA_NIBBLES);
`endif

`ifdef ETH_FCS_PAD_EN
  typedef enum logic [2:0] {StIdle, StPre, StData, StPad, StFcs, StIfg, StBlock} state_e;
`else
  typedef enum logic [2:0] {StIdle, StPre, StData, StFcs, StIfg, StBlock} state_e;
`endif

  state_e            state_q;
  logic [31:0]       crc_q;
  logic [10:0]       nib_cnt_q;
  logic [2:0]        fcs_idx_q;
  logic [IfgW-1:0]   ifg_cnt_q;
  logic              ign_q;     // currently swallowing a colliding input run
  logic [3:0]        txd_q;
  logic              tx_en_q;
  logic              busy_q;
  logic              err_q;
  logic [7:0]        drop_q;
  logic              tail_state;

  // Reflected CRC-32, one nibble, LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] crc, input logic [3:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      c = (c >> 1) ^ ((c[0] ^ d[i]) ? CrcPoly : 32'h0);
    end
    return c;
  endfunction

  // States in which a rising valid is a collision rather than a new frame.
  always_comb begin
    tail_state = (state_q == StFcs) || (state_q == StIfg);
`ifdef ETH_FCS_PAD_EN
    tail_state = tail_state || (state_q == StPad);
`endif
  end

  always_ff @(posedge eth_clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      crc_q     <= CrcInit;
      nib_cnt_q <= '0;
      fcs_idx_q <= '0;
      ifg_cnt_q <= '0;
      ign_q     <= 1'b0;
      txd_q     <= 4'h0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      err_q <= 1'b0;

      // Count each colliding run once, however long it stays high.
      if (tail_state) begin
        if (!bus.with_usr_valid) begin
          ign_q <= 1'b0;
        end else if (!ign_q) begin
          ign_q <= 1'b1;
          if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
      end

      unique case (state_q)
        StIdle: begin
          txd_q   <= 4'h0;
          tx_en_q <= 1'b0;
          ign_q   <= 1'b0;
          if (bus.with_usr_valid) begin
            txd_q   <= bus.with_usr;
            tx_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StPre;
          end
        end

        StPre: begin
          if (bus.with_usr_valid) begin
            txd_q   <= bus.with_usr;
            tx_en_q <= 1'b1;
            if (bus.with_usr == 4'hD) begin
              crc_q     <= CrcInit;
              nib_cnt_q <= '0;
              state_q   <= StData;
            end
          end else begin
            // Aborted before SFD: no FCS; this edge already starts the gap.
            txd_q     <= 4'h0;
            tx_en_q   <= 1'b0;
            err_q     <= 1'b1;
            ifg_cnt_q <= IfgW'(1);
            state_q   <= StIfg;
          end
        end

        StData: begin
          if (bus.with_usr_valid) begin
            txd_q   <= bus.with_usr;
            tx_en_q <= 1'b1;
            crc_q   <= crc_nib(crc_q, bus.with_usr);
            if (nib_cnt_q != 11'h7FF) nib_cnt_q <= nib_cnt_q + 11'd1;
          end
`ifdef ETH_FCS_PAD_EN
          else if (nib_cnt_q < MinNib) begin
            txd_q     <= 4'h0;
            tx_en_q   <= 1'b1;
            crc_q     <= crc_nib(crc_q, 4'h0);
            nib_cnt_q <= nib_cnt_q + 11'd1;
            state_q   <= StPad;
          end
`endif
          else begin
            // First FCS nibble; crc_q shifts so the next nibble is always at [3:0].
            txd_q     <= ~crc_q[3:0];
            tx_en_q   <= 1'b1;
            err_q     <= nib_cnt_q[0];
            crc_q     <= crc_q >> 4;
            fcs_idx_q <= 3'd1;
            state_q   <= StFcs;
          end
        end

`ifdef ETH_FCS_PAD_EN
        StPad: begin
          if (nib_cnt_q < MinNib) begin
            txd_q     <= 4'h0;
            tx_en_q   <= 1'b1;
            crc_q     <= crc_nib(crc_q, 4'h0);
            nib_cnt_q <= nib_cnt_q + 11'd1;
          end else begin
            txd_q     <= ~crc_q[3:0];
            tx_en_q   <= 1'b1;
            err_q     <= nib_cnt_q[0];
            crc_q     <= crc_q >> 4;
            fcs_idx_q <= 3'd1;
            state_q   <= StFcs;
          end
        end
`endif

        StFcs: begin
          txd_q     <= ~crc_q[3:0];
          tx_en_q   <= 1'b1;
          crc_q     <= crc_q >> 4;
          fcs_idx_q <= fcs_idx_q + 3'd1;
          if (fcs_idx_q == 3'd7) begin
            ifg_cnt_q <= '0;
            state_q   <= StIfg;
          end
        end

        StIfg: begin
          txd_q   <= 4'h0;
          tx_en_q <= 1'b0;
          if (ifg_cnt_q == IfgW'(IFG_NIBBLES)) begin
            if (bus.with_usr_valid) begin
              state_q <= StBlock;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            ifg_cnt_q <= ifg_cnt_q + IfgW'(1);
          end
        end

        StBlock: begin
          txd_q   <= 4'h0;
          tx_en_q <= 1'b0;
          if (!bus.with_usr_valid) begin
            busy_q  <= 1'b0;
            ign_q   <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.eth_txd   = txd_q;
  assign bus.eth_tx_en = tx_en_q;
  assign bus.tx_busy   = busy_q;
  assign bus.frame_err = err_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_eth_fcs_append.sv
module tb_eth_fcs_append;
  localparam int unsigned IFG = 24;
`ifdef ETH_FCS_PAD_EN
  localparam int unsigned MIN_NIB = 120;
`endif

  logic eth_clk = 1'b0;
  logic rst_n;

  eth_fcs_if bus ();

  eth_fcs_append dut (
    .eth_clk (eth_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 eth_clk = ~eth_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          n_pre;
    bit          sfd;
    int          n_data;
    bit          exp_err;
    bit          use_fcs;
    logic [31:0] fcs;
  } vec_t;

  vec_t  vecs[4];
  string vec_name[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge eth_clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [3:0] txd, input logic en,
                           input logic busy, input logic err);
    chk({name, ".txd"}, 32'(bus.eth_txd), 32'(txd));
    chk({name, ".tx_en"}, 32'(bus.eth_tx_en), 32'(en));
    chk({name, ".tx_busy"}, 32'(bus.tx_busy), 32'(busy));
    chk({name, ".frame_err"}, 32'(bus.frame_err), 32'(err));
  endtask

  // Payload is "123456789" repeated, low nibble of each byte first.
  function automatic logic [3:0] data_nib(input int i);
    logic [7:0] b;
    b = 8'h31 + 8'((i / 2) % 9);
    return (i % 2 == 1) ? b[7:4] : b[3:0];
  endfunction

  // Bit-serial reference CRC-32 over the post-SFD nibble stream; returns the FCS value.
  function automatic logic [31:0] ref_fcs(input logic [3:0] nibs[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (nibs[n]) begin
      for (int b = 0; b < 4; b++) begin
        fb = c[0] ^ nibs[n][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic drive_nib(input string name, input logic [3:0] n);
    bus.with_usr_valid = 1'b1;
    bus.with_usr       = n;
    step();
    check_out({name, ".echo"}, n, 1'b1, 1'b1, 1'b0);
  endtask

  // Sends one frame and checks the echo, pad/FCS, gap and busy release. Valid is re-raised
  // (with junk data) for tail cycles c in [cs, ce), c = 0 being the cycle valid first falls.
  task automatic run_frame(input string name, input int n_pre, input bit sfd, input int n_data,
                           input bit exp_err, input bit use_fcs, input logic [31:0] fcs_const,
                           input int cs, input int ce);
    logic [3:0]  post[$];
    logic [3:0]  e_txd[$];
    logic        e_en[$];
    logic        e_err[$];
    logic [31:0] fcs;
    int          c;
    for (int i = 0; i < n_pre; i++) drive_nib(name, 4'h5);
    if (sfd) begin
      drive_nib(name, 4'hD);
      for (int i = 0; i < n_data; i++) begin
        post.push_back(data_nib(i));
        drive_nib(name, data_nib(i));
      end
`ifdef ETH_FCS_PAD_EN
      while (post.size() < MIN_NIB) begin
        post.push_back(4'h0);
        e_txd.push_back(4'h0); e_en.push_back(1'b1); e_err.push_back(1'b0);
      end
`endif
      fcs = use_fcs ? fcs_const : ref_fcs(post);
      for (int k = 0; k < 8; k++) begin
        e_txd.push_back(fcs[4*k +: 4]); e_en.push_back(1'b1); e_err.push_back(k == 0 && exp_err);
      end
      for (int k = 0; k < IFG; k++) begin
        e_txd.push_back(4'h0); e_en.push_back(1'b0); e_err.push_back(1'b0);
      end
    end else begin
      for (int k = 0; k < IFG; k++) begin
        e_txd.push_back(4'h0); e_en.push_back(1'b0); e_err.push_back(k == 0 && exp_err);
      end
    end
    for (c = 0; c < e_txd.size(); c++) begin
      bus.with_usr_valid = (c >= cs && c < ce);
      bus.with_usr       = 4'hA;
      step();
      check_out({name, ".tail"}, e_txd[c], e_en[c], 1'b1, e_err[c]);
    end
    // Gap expired with a dropped run still high: stay blocked until it falls.
    while (c >= cs && c < ce) begin
      bus.with_usr_valid = 1'b1;
      step();
      check_out({name, ".blocked"}, 4'h0, 1'b0, 1'b1, 1'b0);
      c++;
    end
    bus.with_usr_valid = 1'b0;
    bus.with_usr       = 4'h0;
    step();
    check_out({name, ".idle"}, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.with_usr       = 4'h0;
    bus.with_usr_valid = 1'b0;
    repeat (3) step();
    check_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.drop_cnt", 32'(bus.drop_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    vec_name[0] = "std";
    vec_name[1] = "short_pre";
    vec_name[2] = "odd17";
    vec_name[3] = "tiny4";
`ifdef ETH_FCS_PAD_EN
    vecs[0] = '{n_pre: 15, sfd: 1'b1, n_data: 18, exp_err: 1'b0, use_fcs: 1'b0, fcs: 32'h0};
    vecs[2] = '{n_pre: 15, sfd: 1'b1, n_data: 17, exp_err: 1'b0, use_fcs: 1'b0, fcs: 32'h0};
`else
    vecs[0] = '{n_pre: 15, sfd: 1'b1, n_data: 18, exp_err: 1'b0, use_fcs: 1'b1,
                fcs: 32'hCBF43926};
    vecs[2] = '{n_pre: 15, sfd: 1'b1, n_data: 17, exp_err: 1'b1, use_fcs: 1'b0, fcs: 32'h0};
`endif
    vecs[1] = '{n_pre: 6, sfd: 1'b0, n_data: 0, exp_err: 1'b1, use_fcs: 1'b0, fcs: 32'h0};
    vecs[3] = '{n_pre: 7, sfd: 1'b1, n_data: 4, exp_err: 1'b0, use_fcs: 1'b0, fcs: 32'h0};

    for (int v = 0; v < 4; v++) begin
      run_frame(vec_name[v], vecs[v].n_pre, vecs[v].sfd, vecs[v].n_data, vecs[v].exp_err,
                vecs[v].use_fcs, vecs[v].fcs, 0, 0);
    end
    chk("no_drop_yet", 32'(bus.drop_cnt), 32'd0);

    // Second frame rises inside the FCS and must be swallowed.
    run_frame("coll_fcs", 15, 1'b1, 18, 1'b0, 1'b0, 32'h0, 5, 15);
    chk("coll_fcs.drop_cnt", 32'(bus.drop_cnt), 32'd1);

    // Run rises inside the gap and outlives it.
    run_frame("coll_ifg", 15, 1'b1, 18, 1'b0, 1'b0, 32'h0, 20, 40 + IFG);
    chk("coll_ifg.drop_cnt", 32'(bus.drop_cnt), 32'd2);

    // Reset mid-DATA aborts at once.
    for (int i = 0; i < 15; i++) drive_nib("rst_mid", 4'h5);
    drive_nib("rst_mid", 4'hD);
    for (int i = 0; i < 6; i++) drive_nib("rst_mid", data_nib(i));
    rst_n              = 1'b0;
    bus.with_usr_valid = 1'b0;
    bus.with_usr       = 4'h0;
    step();
    check_out("rst_mid.after", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.drop_cnt", 32'(bus.drop_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    check_out("rst_mid.idle", 4'h0, 1'b0, 1'b0, 1'b0);
    run_frame("post_rst", 15, 1'b1, 18, 1'b0, 1'b0, 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
